// File: rtl/proc_pkg.sv
// Shared processor constants and the program-loader state encoding.
// The CKSUM state only exists when PROGRAM_LOADER_CKSUM_EN is defined.
package proc_pkg;

    localparam int unsigned INST_W     = 16;
    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned CNT_W      = IMEM_AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3
`ifdef PROGRAM_LOADER_CKSUM_EN
        ,
        ST_CKSUM = 3'd4
`endif
    } loader_state_t;

endpackage

// File: rtl/program_ram.sv
// 16x16 instruction store: synchronous write port for the loader,
// combinational read port for instruction fetch (drop-in for the ROM).
module program_ram
    import proc_pkg::*;
(
    input  logic                clk,
    input  logic                we,
    input  logic [IMEM_AW-1:0]  addr,
    input  logic [INST_W-1:0]   wdata,
    input  logic [IMEM_AW-1:0]  rd_addr,
    output logic [INST_W-1:0]   rd_data
);

    logic [INST_W-1:0] mem [IMEM_DEPTH];

    // Contents are deliberately not reset so a partial load survives a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: packs byte pairs high-first into instructions and
// writes words 0..15 while holding the CPU. Optional checksum: PROGRAM_LOADER_CKSUM_EN.
module program_loader
    import proc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                mem_we,
    output logic [IMEM_AW-1:0]  mem_addr,
    output logic [INST_W-1:0]   mem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    load_count,
    output logic                cks_err
);

    loader_state_t       state, state_n;
    logic [BYTE_W-1:0]   hi_q, hi_n;
    logic [IMEM_AW-1:0]  addr_q, addr_n;
    logic [IMEM_AW-1:0]  mem_addr_n;
    logic [INST_W-1:0]   mem_wdata_n;
    logic [CNT_W-1:0]    load_count_n;
    logic                mem_we_n, byte_ready_n, busy_n, cpu_hold_n, done_n;
    logic                xfer;

`ifdef PROGRAM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0]   xor_q, xor_n;
    logic                cks_err_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hi_q       <= '0;
            addr_q     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            load_count <= '0;
            mem_we     <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            hi_q       <= hi_n;
            addr_q     <= addr_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            load_count <= load_count_n;
            mem_we     <= mem_we_n;
            byte_ready <= byte_ready_n;
            busy       <= busy_n;
            cpu_hold   <= cpu_hold_n;
            done       <= done_n;
        end
    end

`ifdef PROGRAM_LOADER_CKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xor_q   <= '0;
            cks_err <= 1'b0;
        end else begin
            xor_q   <= xor_n;
            cks_err <= cks_err_n;
        end
    end
`else
    assign cks_err = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        hi_n         = hi_q;
        addr_n       = addr_q;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        load_count_n = load_count;
        busy_n       = busy;
        cpu_hold_n   = cpu_hold;
        done_n       = done;
`ifdef PROGRAM_LOADER_CKSUM_EN
        xor_n        = xor_q;
        cks_err_n    = cks_err;
`endif
        xfer         = byte_valid & byte_ready;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n      = ST_HI;
                    addr_n       = '0;
                    load_count_n = '0;
                    done_n       = 1'b0;
                    busy_n       = 1'b1;
                    cpu_hold_n   = 1'b1;
`ifdef PROGRAM_LOADER_CKSUM_EN
                    xor_n        = '0;
                    cks_err_n    = 1'b0;
`endif
                end
            end
            ST_HI: begin
                if (xfer) begin
                    hi_n    = byte_in;
                    state_n = ST_LO;
`ifdef PROGRAM_LOADER_CKSUM_EN
                    xor_n   = xor_q ^ byte_in;
`endif
                end
            end
            ST_LO: begin
                // Word count advances together with the write strobe it accounts for.
                if (xfer) begin
                    mem_wdata_n  = {hi_q, byte_in};
                    mem_addr_n   = addr_q;
                    load_count_n = load_count + CNT_W'(1);
                    state_n      = ST_WRITE;
`ifdef PROGRAM_LOADER_CKSUM_EN
                    xor_n        = xor_q ^ byte_in;
`endif
                end
            end
            ST_WRITE: begin
                if (addr_q == IMEM_AW'(IMEM_DEPTH - 1)) begin
`ifdef PROGRAM_LOADER_CKSUM_EN
                    state_n    = ST_CKSUM;
`else
                    state_n    = ST_IDLE;
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    cpu_hold_n = 1'b0;
`endif
                end else begin
                    addr_n  = addr_q + IMEM_AW'(1);
                    state_n = ST_HI;
                end
            end
`ifdef PROGRAM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (xfer) begin
                    cks_err_n  = (byte_in != xor_q);
                    done_n     = 1'b1;
                    busy_n     = 1'b0;
                    cpu_hold_n = 1'b0;
                    state_n    = ST_IDLE;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort cancels anything captured this cycle, including a low-byte transfer.
        if (abort && (state != ST_IDLE)) begin
            state_n      = ST_IDLE;
            hi_n         = hi_q;
            mem_addr_n   = mem_addr;
            mem_wdata_n  = mem_wdata;
            load_count_n = load_count;
            busy_n       = 1'b0;
            cpu_hold_n   = 1'b0;
            done_n       = 1'b0;
`ifdef PROGRAM_LOADER_CKSUM_EN
            xor_n        = xor_q;
`endif
        end

        mem_we_n     = (state_n == ST_WRITE);
`ifdef PROGRAM_LOADER_CKSUM_EN
        byte_ready_n = (state_n == ST_HI) || (state_n == ST_LO) || (state_n == ST_CKSUM);
`else
        byte_ready_n = (state_n == ST_HI) || (state_n == ST_LO);
`endif
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with program_ram on its write port.
// Random programs are compared against a queue of expected writes and a model RAM.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready, mem_we, cpu_hold, busy, done, cks_err;
    logic [3:0]  mem_addr, rd_addr;
    logic [15:0] mem_wdata, rd_data;
    logic [4:0]  load_count;

`ifdef PROGRAM_LOADER_CKSUM_EN
    localparam bit CKS_EN = 1'b1;
`else
    localparam bit CKS_EN = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  prog [32];
    logic [15:0] model_mem [16];
    bit          known [16];
    logic [19:0] exp_q [$];

    program_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .load_count(load_count), .cks_err(cks_err)
    );

    program_ram u_ram (
        .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest word the model expects.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(mem_addr), 32'hdead);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("we_addr", 32'(mem_addr), 32'(e[19:16]));
                check("we_data", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic gen_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
    endtask

    function automatic logic [7:0] prog_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 32; i++) x ^= prog[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input int w, input int gap_max, input int lo_gap);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        send_byte(prog[2*w]);
        repeat (lo_gap) @(negedge clk);
        exp_q.push_back({4'(w), prog[2*w], prog[2*w+1]});
        model_mem[w] = {prog[2*w], prog[2*w+1]};
        known[w]     = 1'b1;
        send_byte(prog[2*w+1]);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_count", 32'(load_count), 32'd0);
        check("start_ready", 32'(byte_ready), 32'd1);
    endtask

    task automatic finish_load(input bit corrupt);
        @(negedge clk);
        check("we_latency", 32'(mem_we), 32'd1);
        @(negedge clk);
        if (CKS_EN) begin
            check("cks_busy", 32'(busy), 32'd1);
            check("cks_hold", 32'(cpu_hold), 32'd1);
            check("cks_done", 32'(done), 32'd0);
            send_byte(prog_xor() ^ {7'd0, corrupt});
            @(negedge clk);
        end
        check("cks_err", 32'(cks_err), 32'(corrupt & CKS_EN));
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_hold", 32'(cpu_hold), 32'd0);
        check("end_count", 32'(load_count), 32'd16);
        check("end_ready", 32'(byte_ready), 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(load_count), 32'd0);
        check({tag, "_cks"}, 32'(cks_err), 32'd0);
    endtask

    task automatic ram_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (known[i]) begin
                rd_addr = 4'(i);
                #1 check(tag, 32'(rd_data), 32'(model_mem[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed first words, back-to-back bytes.
        gen_prog();
        prog[0] = 8'hAE; prog[1] = 8'h01; prog[2] = 8'hFE; prog[3] = 8'h00;
        do_start();
        for (int w = 0; w < 16; w++) begin
            send_word(w, 0, 0);
            if (w == 7) begin
                check("mid_busy", 32'(busy), 32'd1);
                check("mid_hold", 32'(cpu_hold), 32'd1);
            end
        end
        finish_load(1'b0);
        ram_check("ram_full1");

        // Extra bytes after the load are refused.
        @(negedge clk) byte_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("extra_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;

        // start together with abort in IDLE is ignored.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        repeat (2) @(negedge clk);
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_done", 32'(done), 32'd1);
        check("sa_ready", 32'(byte_ready), 32'd0);
        check("sa_count", 32'(load_count), 32'd16);

        // Random gaps, 5-cycle gap inside word 3, start pulse while busy.
        gen_prog();
        do_start();
        for (int w = 0; w < 16; w++) begin
            send_word(w, 3, (w == 3) ? 5 : $urandom_range(0, 2));
            if (w == 4) begin
                @(negedge clk) start = 1'b1;
                @(negedge clk) start = 1'b0;
                check("busy_start_count", 32'(load_count), 32'd5);
                check("busy_start_busy", 32'(busy), 32'd1);
            end
        end
        finish_load(1'b1);
        ram_check("ram_full2");

        // Abort in LO together with a valid low byte of word 7.
        gen_prog();
        do_start();
        for (int w = 0; w < 7; w++) send_word(w, 1, 0);
        send_byte(prog[14]);
        @(negedge clk);
        check("abort_in_lo", 32'(byte_ready), 32'd1);
        byte_in = prog[15]; byte_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 begin byte_valid = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_count", 32'(load_count), 32'd7);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hold", 32'(cpu_hold), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        ram_check("ram_abort");

        // Asynchronous reset while waiting for the high byte of word 10.
        gen_prog();
        do_start();
        for (int w = 0; w < 10; w++) send_word(w, 1, 1);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_hi", 32'(byte_ready), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk) rst = 1'b0;
        check("rst_pending", 32'(exp_q.size()), 32'd0);
        ram_check("ram_partial");

        // Reload from address 0 after the reset.
        gen_prog();
        do_start();
        for (int w = 0; w < 16; w++) send_word(w, 2, $urandom_range(0, 2));
        finish_load(1'b0);
        ram_check("ram_reload");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
